change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 115 +++++++++++
 tb/tb_change_dispenser.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays a half-unit balance as ten-coin / one-coin eject
// pulses, ten-coins first, falling back to one-coins when a hopper runs dry.
module change_dispenser #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] amount_i,
  input  logic       ten_empty_i,
  input  logic       one_empty_i,
  output logic       tenout_o,
  output logic       oneout_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] balance_o,
  output logic       short_o
);

  typedef enum logic [2:0] {IDLE, DECIDE, PULSE, GAP, DONE} state_t;

  localparam logic [7:0] TEN_VAL    = 8'd20;
  localparam logic [7:0] ONE_VAL    = 8'd2;
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

  state_t     state_q;
  logic [7:0] bal_q;
  logic [7:0] cnt_q;
  logic       ten_q;
  logic       one_q;
  logic       busy_q;
  logic       done_q;
  logic       short_q;

  logic       take_ten_d;
  logic       take_one_d;

  // A coin is only chosen when the balance covers it, so subtraction never wraps.
  assign take_ten_d = (bal_q >= TEN_VAL) && !ten_empty_i;
  assign take_one_d = !take_ten_d && (bal_q >= ONE_VAL) && !one_empty_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bal_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ten_q   <= 1'b0;
      one_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bal_q   <= amount_i;
            busy_q  <= 1'b1;
            state_q <= DECIDE;
          end
        end
        DECIDE: begin
          if (take_ten_d) begin
            ten_q   <= 1'b1;
            bal_q   <= bal_q - TEN_VAL;
            cnt_q   <= PULSE_LAST;
            state_q <= PULSE;
          end else if (take_one_d) begin
            one_q   <= 1'b1;
            bal_q   <= bal_q - ONE_VAL;
            cnt_q   <= PULSE_LAST;
            state_q <= PULSE;
          end else begin
            done_q  <= 1'b1;
            short_q <= (bal_q >= ONE_VAL);
            state_q <= DONE;
          end
        end
        PULSE: begin
          if (cnt_q == 8'd0) begin
            ten_q   <= 1'b0;
            one_q   <= 1'b0;
            cnt_q   <= GAP_LAST;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        GAP: begin
          if (cnt_q == 8'd0) begin
            state_q <= DECIDE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          short_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tenout_o  = ten_q;
  assign oneout_o  = one_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign balance_o = bal_q;
  assign short_o   = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table vectors, hand-written corner
// sequences and random payouts compared cycle by cycle against a timeline model.
module tb_change_dispenser;

  localparam int PC = 4;
  localparam int GC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       tenEmpty;
  logic       oneEmpty;
  logic       tenOut;
  logic       oneOut;
  logic       busy;
  logic       done;
  logic [7:0] balance;
  logic       shortFlag;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       ten;
    logic       one;
    logic       busy;
    logic       done;
    logic       shortF;
    logic [7:0] bal;
  } obs_t;

  typedef struct {
    logic [7:0] amount;
    logic       tenEmpty;
    logic       oneEmpty;
    int         expTen;
    int         expOne;
    int         expBal;
    int         expShort;
  } vec_t;

  obs_t expQ[$];

  always #5 clk = ~clk;

  change_dispenser #(.PULSE_CYC(PC), .GAP_CYC(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .amount_i   (amount),
    .ten_empty_i(tenEmpty),
    .one_empty_i(oneEmpty),
    .tenout_o   (tenOut),
    .oneout_o   (oneOut),
    .busy_o     (busy),
    .done_o     (done),
    .balance_o  (balance),
    .short_o    (shortFlag)
  );

  // Hard stop in case a bounded wait is ever missed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  function automatic obs_t mkObs(input logic t, input logic o, input logic b,
                                 input logic d, input logic s, input int bal);
    obs_t e;
    e.ten    = t;
    e.one    = o;
    e.busy   = b;
    e.done   = d;
    e.shortF = s;
    e.bal    = 8'(bal);
    return e;
  endfunction

  function automatic obs_t sampleDut();
    return mkObs(tenOut, oneOut, busy, done, shortFlag, int'(balance));
  endfunction

  // Expected per-cycle timeline from the first cycle after the start edge:
  // a decision cycle, then per coin PC high cycles and GC low cycles, repeated
  // greedily (ten first) until nothing payable remains, then a done cycle and idle.
  // Hopper flags switch to (te1,oe1) for decisions at timeline index >= changeAt.
  task automatic buildTrace(input int amt, input logic te0, input logic oe0,
                            input int changeAt, input logic te1, input logic oe1);
    int   b;
    int   coin;
    logic te;
    logic oe;
    b = amt;
    expQ.delete();
    while (1) begin
      te = (changeAt >= 0 && expQ.size() >= changeAt) ? te1 : te0;
      oe = (changeAt >= 0 && expQ.size() >= changeAt) ? oe1 : oe0;
      expQ.push_back(mkObs(0, 0, 1, 0, 0, b));
      if (b >= 20 && !te) coin = 20;
      else if (b >= 2 && !oe) coin = 2;
      else coin = 0;
      if (coin == 0) break;
      b = b - coin;
      repeat (PC) expQ.push_back(mkObs(coin == 20, coin == 2, 1, 0, 0, b));
      repeat (GC) expQ.push_back(mkObs(0, 0, 1, 0, 0, b));
    end
    expQ.push_back(mkObs(0, 0, 1, 1, b >= 2, b));
    expQ.push_back(mkObs(0, 0, 0, 0, 0, b));
  endtask

  // Launches one payout and compares every cycle against the timeline; also
  // tallies pulses and captures the report seen on the done strobe.
  task automatic applyStimulus(input string tag, input int amt, input logic te0,
                               input logic oe0, input int changeAt, input logic te1,
                               input logic oe1, input int injectAt,
                               output int tenCnt, output int oneCnt,
                               output int doneBal, output int doneShort);
    logic prevTen;
    logic prevOne;
    obs_t o;
    buildTrace(amt, te0, oe0, changeAt, te1, oe1);
    tenCnt = 0;
    oneCnt = 0;
    doneBal = -1;
    doneShort = -1;
    prevTen = 1'b0;
    prevOne = 1'b0;
    @(negedge clk);
    tenEmpty = te0;
    oneEmpty = oe0;
    amount   = 8'(amt);
    start    = 1'b1;
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      o = sampleDut();
      checkOutput($sformatf("%s cyc%0d", tag, i), 32'(o), 32'(expQ[i]));
      if (tenOut && !prevTen) tenCnt++;
      if (oneOut && !prevOne) oneCnt++;
      prevTen = tenOut;
      prevOne = oneOut;
      if (done) begin
        doneBal   = int'(balance);
        doneShort = int'(shortFlag);
      end
      if (i == injectAt) begin
        start  = 1'b1;
        amount = 8'd99;
      end
      if (i == changeAt) begin
        tenEmpty = te1;
        oneEmpty = oe1;
      end
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   tc, oc, db, ds;
    logic rte, roe;
    int   ramt;

    vecs.push_back('{8'd46,  1'b0, 1'b0, 2,  3,  0,  0});
    vecs.push_back('{8'd5,   1'b0, 1'b0, 0,  2,  1,  0});
    vecs.push_back('{8'd20,  1'b1, 1'b0, 0,  10, 0,  0});
    vecs.push_back('{8'd40,  1'b1, 1'b1, 0,  0,  40, 1});
    vecs.push_back('{8'd0,   1'b0, 1'b0, 0,  0,  0,  0});
    vecs.push_back('{8'd1,   1'b0, 1'b0, 0,  0,  1,  0});
    vecs.push_back('{8'd255, 1'b0, 1'b0, 12, 7,  1,  0});
    vecs.push_back('{8'd30,  1'b0, 1'b1, 1,  0,  10, 1});
    vecs.push_back('{8'd3,   1'b0, 1'b1, 0,  0,  3,  1});

    rst = 1'b1;
    start = 1'b1;
    amount = 8'd50;
    tenEmpty = 1'b0;
    oneEmpty = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", 32'(sampleDut()), 32'(mkObs(0, 0, 0, 0, 0, 0)));
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle after reset", 32'(sampleDut()), 32'(mkObs(0, 0, 0, 0, 0, 0)));

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus($sformatf("vec%0d", v), int'(vecs[v].amount), vecs[v].tenEmpty,
                    vecs[v].oneEmpty, -1, 1'b0, 1'b0, -1, tc, oc, db, ds);
      checkOutput($sformatf("vec%0d tenPulses", v), 32'(tc), 32'(vecs[v].expTen));
      checkOutput($sformatf("vec%0d onePulses", v), 32'(oc), 32'(vecs[v].expOne));
      checkOutput($sformatf("vec%0d doneBal", v), 32'(db), 32'(vecs[v].expBal));
      checkOutput($sformatf("vec%0d doneShort", v), 32'(ds), 32'(vecs[v].expShort));
    end

    // A second start with amount 99 mid-payout must leave the payout untouched.
    applyStimulus("ignoreStart", 46, 1'b0, 1'b0, -1, 1'b0, 1'b0, 6, tc, oc, db, ds);
    checkOutput("ignoreStart tenPulses", 32'(tc), 32'd2);
    checkOutput("ignoreStart onePulses", 32'(oc), 32'd3);
    checkOutput("ignoreStart doneBal", 32'(db), 32'd0);
    @(negedge clk);
    checkOutput("ignoreStart stays idle", 32'(busy), 32'd0);

    // Both hoppers empty out during the first ten pulse; that pulse still runs full length.
    applyStimulus("hopperFlip", 22, 1'b0, 1'b0, 2, 1'b1, 1'b1, -1, tc, oc, db, ds);
    checkOutput("hopperFlip tenPulses", 32'(tc), 32'd1);
    checkOutput("hopperFlip onePulses", 32'(oc), 32'd0);
    checkOutput("hopperFlip doneBal", 32'(db), 32'd2);
    checkOutput("hopperFlip doneShort", 32'(ds), 32'd1);
    tenEmpty = 1'b0;
    oneEmpty = 1'b0;

    // Reset on the second cycle of the first ten pulse, then a clean payout.
    @(negedge clk);
    amount = 8'd22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("midReset pulse up", 32'(tenOut), 32'd1);
    @(negedge clk);
    checkOutput("midReset pulse cyc2", 32'(tenOut), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset cleared", 32'(sampleDut()), 32'(mkObs(0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    checkOutput("midReset idle", 32'(sampleDut()), 32'(mkObs(0, 0, 0, 0, 0, 0)));
    applyStimulus("afterReset", 22, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1, tc, oc, db, ds);
    checkOutput("afterReset tenPulses", 32'(tc), 32'd1);
    checkOutput("afterReset onePulses", 32'(oc), 32'd1);
    checkOutput("afterReset doneBal", 32'(db), 32'd0);

    for (int r = 0; r < 25; r++) begin
      ramt = int'($urandom_range(0, 120));
      rte  = ($urandom_range(0, 3) == 0);
      roe  = ($urandom_range(0, 3) == 0);
      applyStimulus($sformatf("rand%0d", r), ramt, rte, roe, -1, 1'b0, 1'b0, -1,
                    tc, oc, db, ds);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
